// File: rtl/counter_jk.sv
// 3-bit up-counter built from three JK flip-flops; counts in plain binary (mode=0)
// or reflected Gray code (mode=1), always continuing from the current value.
module counter_jk (
   input  logic       reset,
   input  logic       clk,
   input  logic       mode,
   output logic [2:0] count
);

   localparam int unsigned W = 3;

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;
   logic [W-1:0] next_val;
   logic [W-1:0] j;
   logic [W-1:0] k;

   // Successor of the current code in the reflected Gray sequence.
   function automatic logic [W-1:0] gray_succ(input logic [W-1:0] q);
      logic [W-1:0] s;
      s = 3'b000;
      unique case (q)
         3'b000: s = 3'b001;
         3'b001: s = 3'b011;
         3'b011: s = 3'b010;
         3'b010: s = 3'b110;
         3'b110: s = 3'b111;
         3'b111: s = 3'b101;
         3'b101: s = 3'b100;
         3'b100: s = 3'b000;
         default: s = 3'b000;
      endcase
      return s;
   endfunction

   // J/K excitation from (count, mode); binary uses the classic toggle form, Gray the J=~Q&N / K=Q&~N form.
   always_comb begin
      next_val = gray_succ(count_q);
      j        = '0;
      k        = '0;
      if (!mode) begin
         j[0] = 1'b1;
         k[0] = 1'b1;
         j[1] = count_q[0];
         k[1] = count_q[0];
         j[2] = count_q[0] & count_q[1];
         k[2] = count_q[0] & count_q[1];
      end else begin
         j = ~count_q & next_val;
         k = count_q & ~next_val;
      end
   end

   // JK flip-flop characteristic per bit, with synchronous reset taking priority.
   always_comb begin
      count_d = count_q;
      for (int i = 0; i < int'(W); i++) begin
         unique case ({j[i], k[i]})
            2'b00: count_d[i] = count_q[i];
            2'b10: count_d[i] = 1'b1;
            2'b01: count_d[i] = 1'b0;
            2'b11: count_d[i] = ~count_q[i];
            default: count_d[i] = count_q[i];
         endcase
      end
      if (reset) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: tb/tb_counter_jk.sv
// Directed and randomized checks of counter_jk against a table-driven model of
// the binary and Gray sequences.
module tb_counter_jk;

   logic       clk;
   logic       reset;
   logic       mode;
   logic [2:0] count;

   int checks;
   int errors;
   logic [2:0] model;
   logic [2:0] gray_tab [8];

   counter_jk dut (
      .reset (reset),
      .clk   (clk),
      .mode  (mode),
      .count (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2:0] succ(input logic [2:0] c, input logic m);
      int idx;
      if (!m) return 3'((int'(c) + 1) % 8);
      idx = 0;
      for (int i = 0; i < 8; i++) if (gray_tab[i] == c) idx = i;
      return gray_tab[(idx + 1) % 8];
   endfunction

   task automatic check(input string tag, input logic [2:0] exp);
      checks++;
      assert (count === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, count, exp);
      end
   endtask

   // Drive inputs away from the edge, clock once, update model, compare.
   task automatic step(input logic r, input logic m, input string tag);
      @(negedge clk);
      reset = r;
      mode  = m;
      @(posedge clk);
      #1;
      model = r ? 3'b000 : succ(model, m);
      check(tag, model);
   endtask

   initial begin
      logic [2:0] start;
      checks = 0;
      errors = 0;
      gray_tab = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
      reset = 1'b1;
      mode  = 1'b0;
      model = 3'b000;
      #21;
      check("reset_state", 3'b000);

      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, "binary_run");
      for (int i = 0; i < 6; i++)  step(1'b0, 1'b0, "binary_to_zero");
      check("binary_at_zero", 3'b000);
      for (int i = 0; i < 9; i++)  step(1'b0, 1'b1, "gray_run");
      check("gray_end", 3'b001);

      step(1'b0, 1'b0, "pre_switch");
      step(1'b0, 1'b0, "pre_switch");
      check("at_011", 3'b011);
      step(1'b0, 1'b1, "switch_to_gray");
      check("switch_to_gray_lit", 3'b010);
      step(1'b0, 1'b1, "gray_to_110");
      step(1'b0, 1'b0, "switch_to_binary");
      check("switch_to_binary_lit", 3'b111);

      step(1'b1, 1'b1, "reset_mid_gray");
      step(1'b1, 1'b1, "reset_hold");
      step(1'b0, 1'b1, "after_reset_gray");
      check("after_reset_lit", 3'b001);

      // Every count in both modes: reach start value in binary, then one step in mode m.
      for (int m = 0; m < 2; m++) begin
         for (int v = 0; v < 8; v++) begin
            start = 3'(v);
            step(1'b1, 1'b0, "exh_reset");
            for (int s = 0; s < v; s++) step(1'b0, 1'b0, "exh_reach");
            check("exh_start", start);
            step(1'b0, 1'(m), "exh_next");
         end
      end

      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), "random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
